// File: rtl/audio_mem_arbiter.sv
// rtl/audio_mem_arbiter.sv - single-port memory arbiter between CPU load/store and codec DMA sample fetch
// One transaction in flight; DMA wins ties unless the CPU has been starved MAX_STALL cycles.
module audio_mem_arbiter #(
  parameter int RD_LAT    = 2,
  parameter int MAX_STALL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_iorw,
  input  logic [23:0] cpu_addr,
  input  logic [23:0] cpu_wdata,
  output logic [23:0] cpu_rdata,
  output logic        cpu_rdy,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic [23:0] dma_addr,
  output logic [23:0] dma_rdata,
  output logic        dma_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [23:0] mem_wdata,
  input  logic [23:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);
  localparam logic [2:0] STALL_LIM = 3'(MAX_STALL);

  state_t     state;
  logic       owner_cpu;
  logic       is_read;
  logic [2:0] wait_cnt;
  logic [2:0] starve_cnt;
  logic       grant_cpu;
  logic       cpu_waiting;

  assign cpu_stall   = cpu_en & ~cpu_rdy;
  assign grant_cpu   = cpu_en & (~dma_req | (starve_cnt >= STALL_LIM));
  // The CPU only accrues starvation while someone else holds the memory or it loses in IDLE.
  assign cpu_waiting = ~((state != IDLE) & owner_cpu);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_cpu  <= 1'b0;
      is_read    <= 1'b0;
      wait_cnt   <= 3'd0;
      starve_cnt <= 3'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 24'h000000;
      mem_wdata  <= 24'h000000;
      cpu_rdata  <= 24'h000000;
      dma_rdata  <= 24'h000000;
      cpu_rdy    <= 1'b0;
      dma_valid  <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      cpu_rdy   <= 1'b0;
      dma_valid <= 1'b0;

      if (!cpu_en) begin
        starve_cnt <= 3'd0;
      end else if ((state == IDLE) && grant_cpu) begin
        starve_cnt <= 3'd0;
      end else if (cpu_waiting && (starve_cnt != 3'd7)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end

      case (state)
        IDLE: begin
          if (cpu_en || dma_req) begin
            owner_cpu <= grant_cpu;
            is_read   <= grant_cpu ? cpu_iorw : 1'b1;
            mem_addr  <= grant_cpu ? cpu_addr : dma_addr;
            if (grant_cpu) begin
              mem_wdata <= cpu_wdata;
            end
            mem_en <= 1'b1;
            mem_we <= grant_cpu & ~cpu_iorw;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_INIT;
          if (is_read) begin
            state <= WAIT;
          end else begin
            cpu_rdy <= 1'b1;
            state   <= DONE;
          end
        end
        WAIT: begin
          // Data is valid in the cycle RD_LAT after mem_en, i.e. the last WAIT cycle.
          if (wait_cnt == 3'd0) begin
            if (owner_cpu) begin
              cpu_rdata <= mem_rdata;
              cpu_rdy   <= 1'b1;
            end else begin
              dma_rdata <= mem_rdata;
              dma_valid <= 1'b1;
            end
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
